fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage_if_id_reg.sv | 55 +++++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RVX10 fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold,
    StDiscard
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge channel between fetch and imem.
interface fetch_stage_if;

  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRData;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemAck,
    input  ImemRData
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemAck,
    output ImemRData
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset > flush > stall > load > bubble.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcIn,
  input  logic [31:0] pcPlus4In,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        valid
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pcPlus4_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= 32'h0;
      pcPlus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end else if (flush) begin
      // Flush only kills the instruction; PC fields keep their old values.
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (stall) begin
      instr_q   <= instr_q;
      pc_q      <= pc_q;
      pcPlus4_q <= pcPlus4_q;
      valid_q   <= valid_q;
    end else if (load) begin
      instr_q   <= instrIn;
      pc_q      <= pcIn;
      pcPlus4_q <= pcPlus4In;
      valid_q   <= 1'b1;
    end else begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end
  end

  assign instr   = instr_q;
  assign pc      = pc_q;
  assign pcPlus4 = pcPlus4_q;
  assign valid   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RVX10 instruction fetch: owns PCF, issues one request at a time to a
// variable-latency imem, and feeds the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 PCSrcE,
  input  logic [31:0]          PCTargetE,
  fetch_stage_if.master        imem,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PCPlus4D,
  output logic                 ValidD,
  output logic                 FetchBusyF
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pcF_q, pcF_d;
  logic [31:0]  reqAddr_q, reqAddr_d;
  logic [31:0]  bufInstr_q, bufInstr_d;

  logic [31:0]  pcPlus4F;
  logic         available;
  logic [31:0]  availInstr;
  logic         deliver;

  always_comb begin
    pcPlus4F   = pcF_q + 32'd4;
    available  = ((state_q == StWait) && imem.ImemAck) || (state_q == StHold);
    availInstr = (state_q == StHold) ? bufInstr_q : imem.ImemRData;
    // A redirect always beats a stall and kills whatever is available.
    deliver    = available && !PCSrcE && !StallF;

    imem.ImemReq  = !reset && (state_q != StHold);
    imem.ImemAddr = (state_q == StIdle) ? pcF_q : reqAddr_q;
    FetchBusyF    = reset || !available;
  end

  always_comb begin
    state_d    = state_q;
    pcF_d      = pcF_q;
    reqAddr_d  = reqAddr_q;
    bufInstr_d = bufInstr_q;

    if (PCSrcE) begin
      pcF_d = PCTargetE;
    end else if (deliver) begin
      pcF_d = pcPlus4F;
    end

    unique case (state_q)
      StIdle: begin
        reqAddr_d = pcF_q;
        // The request goes out this cycle regardless, so a redirect must drop its response.
        state_d   = PCSrcE ? StDiscard : StWait;
      end
      StWait: begin
        if (imem.ImemAck) begin
          if (PCSrcE) begin
            state_d = StIdle;
          end else if (StallF) begin
            state_d    = StHold;
            bufInstr_d = imem.ImemRData;
          end else begin
            state_d = StIdle;
          end
        end else if (PCSrcE) begin
          state_d = StDiscard;
        end
      end
      StHold: begin
        if (PCSrcE || !StallF) begin
          state_d = StIdle;
        end
      end
      StDiscard: begin
        if (imem.ImemAck) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pcF_q      <= RESET_PC;
      reqAddr_q  <= RESET_PC;
      bufInstr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pcF_q      <= pcF_d;
      reqAddr_q  <= reqAddr_d;
      bufInstr_q <= bufInstr_d;
    end
  end

  fetch_stage_if_id_reg u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .flush     (FlushD),
    .stall     (StallD),
    .load      (deliver),
    .instrIn   (availInstr),
    .pcIn      (pcF_q),
    .pcPlus4In (pcPlus4F),
    .instr     (InstrD),
    .pc        (PCD),
    .pcPlus4   (PCPlus4D),
    .valid     (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level fetch model
// and a variable-latency memory model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusyF;

  fetch_stage_if imem ();

  fetch_stage #(
    .RESET_PC (ResetPc)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem       (imem),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FetchBusyF (FetchBusyF)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Fetch model: architectural PC, one outstanding request (maybe doomed), one held instruction.
  logic [31:0] mPc, mReqAddr, mBuf;
  logic        mOut, mDrop, mHeld;
  logic [31:0] eInstr, ePcd, ePc4;
  logic        eValid;

  // Memory model.
  logic        memBusy;
  int          memCnt;
  logic [31:0] memAddr;

  logic        ack, expReq, avail, deliver, directed, stall;
  logic [31:0] expAddr, rdata, availData;

  initial begin
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0;
    imem.ImemAck = 1'b0; imem.ImemRData = 32'h0;
    repeat (2) @(posedge clk);

    mPc = ResetPc; mReqAddr = 32'h0; mBuf = 32'h0;
    mOut = 1'b0; mDrop = 1'b0; mHeld = 1'b0;
    eInstr = NOP_INSTR; ePcd = 32'h0; ePc4 = 32'h0; eValid = 1'b0;
    memBusy = 1'b0; memCnt = 0; memAddr = 32'h0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      directed = (cyc < 24);
      reset  = (cyc < 2) || (!directed && $urandom_range(63) == 0);
      stall  = !directed && ($urandom_range(3) == 0);
      StallF = stall;
      StallD = stall;
      FlushD = !directed && ($urandom_range(9) == 0);
      PCSrcE = !directed && ($urandom_range(7) == 0);
      if ($urandom_range(3) == 0) PCTargetE = 32'hFFFF_FFFC;
      else PCTargetE = $urandom;

      ack   = memBusy && (memCnt == 0);
      rdata = ack ? memWord(memAddr) : $urandom;
      imem.ImemAck   = ack;
      imem.ImemRData = rdata;

      expReq  = !reset && !mHeld;
      expAddr = mOut ? mReqAddr : mPc;
      avail   = (mOut && !mDrop && ack) || mHeld;

      #1;
      check_eq("ImemReq", {31'h0, imem.ImemReq}, {31'h0, expReq});
      if (expReq) check_eq("ImemAddr", imem.ImemAddr, expAddr);
      check_eq("FetchBusyF", {31'h0, FetchBusyF}, {31'h0, reset || !avail});
      check_eq("ValidD", {31'h0, ValidD}, {31'h0, eValid});
      check_eq("InstrD", InstrD, eInstr);
      check_eq("PCD", PCD, ePcd);
      check_eq("PCPlus4D", PCPlus4D, ePc4);

      if (reset) begin
        mPc = ResetPc; mOut = 1'b0; mDrop = 1'b0; mHeld = 1'b0; mBuf = 32'h0;
        eInstr = NOP_INSTR; ePcd = 32'h0; ePc4 = 32'h0; eValid = 1'b0;
        memBusy = 1'b0;
      end else begin
        availData = mHeld ? mBuf : rdata;
        deliver   = avail && !PCSrcE && !StallF;

        if (FlushD) begin
          eInstr = NOP_INSTR;
          eValid = 1'b0;
        end else if (!StallD) begin
          if (deliver) begin
            eInstr = availData; ePcd = mPc; ePc4 = mPc + 32'd4; eValid = 1'b1;
          end else begin
            eInstr = NOP_INSTR; eValid = 1'b0;
          end
        end

        if (mHeld) begin
          if (PCSrcE || !StallF) mHeld = 1'b0;
        end else if (!mOut) begin
          mOut = 1'b1; mReqAddr = mPc; mDrop = PCSrcE;
        end else if (ack) begin
          mOut = 1'b0;
          if (!mDrop && !PCSrcE && StallF) begin
            mHeld = 1'b1; mBuf = rdata;
          end
          mDrop = 1'b0;
        end else if (PCSrcE) begin
          mDrop = 1'b1;
        end

        if (PCSrcE) mPc = PCTargetE;
        else if (deliver) mPc = mPc + 32'd4;

        if (ack) begin
          memBusy = 1'b0;
        end else if (memBusy) begin
          memCnt--;
        end else if (expReq) begin
          memBusy = 1'b1;
          memAddr = expAddr;
          memCnt  = directed ? 0 : int'($urandom_range(2));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
